screen_sequence_ctrl: RTL

- Frame-based sequencer that sits in front of, and behind, the VGA object priority mux.
- Gates each layer's drawing request through a per-layer enable mask.
- Applies a stepped fade-to-black / fade-in to the mux's 8-bit RGB332 output.
- Drives the death and level-transition screen sequences and a game-freeze signal for the game logic.

---
 rtl/screen_sequence_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/screen_sequence_ctrl.sv
// screen_sequence_ctrl: frame-based screen sequencer around the VGA object mux.
// Gates layer drawing requests, fades the mux RGB332 output in stepped levels,
// and runs the death / level-transition sequences, freezing game logic meanwhile.
//
// Ports:
//   clk, resetN      clock, asynchronous active-low reset
//   startOfFrame     one-cycle pulse per frame
//   deathEvent       one-cycle pulse, player died (accepted in PLAY only)
//   levelStartEvent  one-cycle pulse, level change (accepted in PLAY only)
//   restartRequest   one-cycle pulse, leave death screen (accepted in HOLD only)
//   pixelRGBIn       RGB332 pixel from the object mux
//   pixelRGBOut      faded RGB332 pixel, one cycle latency
//   layerEnable      AND-mask for the mux drawing requests
//   fadeLevel        darkening level, 0 = none, 7 = black
//   gameFreeze       high whenever the sequencer is not in PLAY
//   seqState         PLAY=0, FADE_OUT=1, HOLD=2, FADE_IN=3
//   sequenceDone     one-cycle pulse on FADE_IN -> PLAY
module screen_sequence_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned HOLD_FRAMES     = 120,
  parameter int unsigned NUM_LAYERS      = 6
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  deathEvent,
  input  logic                  levelStartEvent,
  input  logic                  restartRequest,
  input  logic [7:0]            pixelRGBIn,
  output logic [7:0]            pixelRGBOut,
  output logic [NUM_LAYERS-1:0] layerEnable,
  output logic [2:0]            fadeLevel,
  output logic                  gameFreeze,
  output logic [1:0]            seqState,
  output logic                  sequenceDone
);

  localparam int unsigned FW = $clog2(FRAMES_PER_STEP + 1);
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

  // Layer masks: normal play, death overlay (score + death foreground), level overlay (score)
  localparam logic [NUM_LAYERS-1:0] MASK_PLAY  = NUM_LAYERS'(6'b011111);
  localparam logic [NUM_LAYERS-1:0] MASK_DEATH = NUM_LAYERS'(6'b110000);
  localparam logic [NUM_LAYERS-1:0] MASK_LEVEL = NUM_LAYERS'(6'b010000);

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    HOLD     = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  typedef enum logic {
    CAUSE_DEATH = 1'b0,
    CAUSE_LEVEL = 1'b1
  } cause_t;

  state_t        state;
  cause_t        cause;
  logic [FW-1:0] frameCnt;
  logic [HW-1:0] holdCnt;

  // Saturating per-channel darkening; blue has one bit less so it fades at half rate
  logic [2:0] r_in, g_in, r_dim_c, g_dim_c;
  logic [1:0] b_in, b_sub, b_dim_c;

  always_comb begin
    r_in    = pixelRGBIn[7:5];
    g_in    = pixelRGBIn[4:2];
    b_in    = pixelRGBIn[1:0];
    b_sub   = fadeLevel[2:1];
    r_dim_c = (r_in > fadeLevel) ? (r_in - fadeLevel) : 3'd0;
    g_dim_c = (g_in > fadeLevel) ? (g_in - fadeLevel) : 3'd0;
    b_dim_c = (b_in > b_sub) ? (b_in - b_sub) : 2'd0;
  end

  // Pixel output register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelRGBOut <= 8'd0;
    end else begin
      pixelRGBOut <= {r_dim_c, g_dim_c, b_dim_c};
    end
  end

  // Sequencer: state, counters and registered control outputs move together
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= PLAY;
      cause        <= CAUSE_DEATH;
      frameCnt     <= '0;
      holdCnt      <= '0;
      fadeLevel    <= 3'd0;
      layerEnable  <= MASK_PLAY;
      gameFreeze   <= 1'b0;
      sequenceDone <= 1'b0;
    end else begin
      sequenceDone <= 1'b0;
      case (state)
        PLAY: begin
          if (deathEvent || levelStartEvent) begin
            state      <= FADE_OUT;
            cause      <= deathEvent ? CAUSE_DEATH : CAUSE_LEVEL;
            frameCnt   <= '0;
            gameFreeze <= 1'b1;
          end
        end

        FADE_OUT: begin
          if (startOfFrame) begin
            if (frameCnt == FRAME_LAST) begin
              frameCnt <= '0;
              if (fadeLevel == 3'd7) begin
                state       <= HOLD;
                fadeLevel   <= 3'd0;
                holdCnt     <= '0;
                layerEnable <= (cause == CAUSE_DEATH) ? MASK_DEATH : MASK_LEVEL;
              end else begin
                fadeLevel <= fadeLevel + 3'd1;
              end
            end else begin
              frameCnt <= frameCnt + FW'(1);
            end
          end
        end

        HOLD: begin
          // Death screen waits for the player; level screen times out on its own
          if (cause == CAUSE_DEATH) begin
            if (restartRequest) begin
              state       <= FADE_IN;
              fadeLevel   <= 3'd7;
              frameCnt    <= '0;
              layerEnable <= MASK_PLAY;
            end
          end else if (startOfFrame) begin
            if (holdCnt == HOLD_LAST) begin
              state       <= FADE_IN;
              fadeLevel   <= 3'd7;
              frameCnt    <= '0;
              layerEnable <= MASK_PLAY;
            end else begin
              holdCnt <= holdCnt + HW'(1);
            end
          end
        end

        FADE_IN: begin
          if (startOfFrame) begin
            if (frameCnt == FRAME_LAST) begin
              frameCnt <= '0;
              if (fadeLevel == 3'd0) begin
                state        <= PLAY;
                gameFreeze   <= 1'b0;
                sequenceDone <= 1'b1;
              end else begin
                fadeLevel <= fadeLevel - 3'd1;
              end
            end else begin
              frameCnt <= frameCnt + FW'(1);
            end
          end
        end

        default: state <= PLAY;
      endcase
    end
  end

  assign seqState = state;

endmodule
